// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph type, hex glyph constants
// (segments a..g, a in the MSB, active-high) and the dark glyph.
package seg7_pkg;

   typedef logic [6:0] glyph_t;

   localparam glyph_t GLYPH_0     = 7'b1111110;
   localparam glyph_t GLYPH_1     = 7'b0110000;
   localparam glyph_t GLYPH_2     = 7'b1101101;
   localparam glyph_t GLYPH_3     = 7'b1111001;
   localparam glyph_t GLYPH_4     = 7'b0110011;
   localparam glyph_t GLYPH_5     = 7'b1011011;
   localparam glyph_t GLYPH_6     = 7'b1011111;
   localparam glyph_t GLYPH_7     = 7'b1110010;
   localparam glyph_t GLYPH_8     = 7'b1111111;
   localparam glyph_t GLYPH_9     = 7'b1111011;
   localparam glyph_t GLYPH_A     = 7'b1110111;
   localparam glyph_t GLYPH_B     = 7'b0011111;
   localparam glyph_t GLYPH_C     = 7'b1001110;
   localparam glyph_t GLYPH_D     = 7'b0111101;
   localparam glyph_t GLYPH_E     = 7'b1001111;
   localparam glyph_t GLYPH_F     = 7'b1000111;
   localparam glyph_t GLYPH_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to seven-segment glyph decoder (active-high).
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   // Look up the glyph for the nibble; dark glyph as the default.
   always_comb begin
      glyph = GLYPH_BLANK;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment display scanner with double-buffered contents.
// New data is staged by load and only swapped into the display register at
// a frame boundary, so a frame never shows a mix of old and new digits.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   data,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      lz_en,
   input  logic                      load,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      upd_ack,
   output logic                      frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic INV = (ACTIVE_LOW != 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0]        presc;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        next_idx;
   logic                    started;
   logic                    tick;
   logic                    wrap;

   logic [4*NUM_DIGITS-1:0] stage_data;
   logic [NUM_DIGITS-1:0]   stage_dp;
   logic [NUM_DIGITS-1:0]   stage_blank;
   logic                    pending;

   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [NUM_DIGITS-1:0]   disp_blank;

   logic [4*NUM_DIGITS-1:0] next_data;
   logic [NUM_DIGITS-1:0]   next_dp;
   logic [NUM_DIGITS-1:0]   next_blank;

   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic                    cur_lz;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [6:0]              glyph_raw;
   logic [6:0]              seg_val;
   logic                    dp_val;

   // The first tick after reset lands on digit 0 without counting as a wrap;
   // a single-digit display wraps on every tick.
   assign tick     = (presc == LAST_CNT);
   assign wrap     = tick && (idx == LAST_IDX) && (started || (NUM_DIGITS == 1));
   assign next_idx = (!started || idx == LAST_IDX) ? '0 : idx + 1'b1;

   // Display contents as they will be after this edge: a load on the wrap
   // cycle bypasses staging, otherwise pending staged data is swapped in.
   always_comb begin
      next_data  = disp_data;
      next_dp    = disp_dp;
      next_blank = disp_blank;
      if (wrap && load) begin
         next_data  = data;
         next_dp    = dp_in;
         next_blank = blank;
      end else if (wrap && pending) begin
         next_data  = stage_data;
         next_dp    = stage_dp;
         next_blank = stage_blank;
      end
   end

   // Pick the digit for the upcoming slot; zero_run tracks whether this
   // nibble and all higher ones are zero, for leading-zero suppression.
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_lz    = 1'b0;
      zero_run  = 1'b1;
      an_next   = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (next_data[4*k +: 4] == 4'h0);
         if (next_idx == IDX_W'(k)) begin
            cur_nib    = next_data[4*k +: 4];
            cur_dp     = next_dp[k];
            cur_blank  = next_blank[k];
            cur_lz     = lz_en && (k != 0) && zero_run;
            an_next[k] = 1'b1;
         end
      end
   end

   seg7_glyph u_glyph (
      .nibble (cur_nib),
      .glyph  (glyph_raw)
   );

   assign seg_val = (cur_blank || cur_lz) ? GLYPH_BLANK : glyph_raw;
   assign dp_val  = cur_dp && !cur_blank;

   // Prescaler and digit index; the index only moves on a tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= '0;
         idx     <= '0;
         started <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            idx     <= next_idx;
            started <= 1'b1;
         end
      end
   end

   // Staging buffer, pending flag and frame-boundary swap into the display register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_data  <= '0;
         stage_dp    <= '0;
         stage_blank <= '0;
         pending     <= 1'b0;
         disp_data   <= '0;
         disp_dp     <= '0;
         disp_blank  <= '0;
         upd_ack     <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         upd_ack    <= 1'b0;
         frame_done <= wrap;
         disp_data  <= next_data;
         disp_dp    <= next_dp;
         disp_blank <= next_blank;
         if (wrap && (load || pending)) begin
            upd_ack <= 1'b1;
            pending <= 1'b0;
         end else if (load) begin
            stage_data  <= data;
            stage_dp    <= dp_in;
            stage_blank <= blank;
            pending     <= 1'b1;
         end
      end
   end

   // Output registers in pin polarity; they hold inactive until the first tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= {7{INV}};
         dp  <= INV;
         an  <= {NUM_DIGITS{INV}};
      end else if (tick) begin
         seg <= seg_val ^ {7{INV}};
         dp  <= dp_val ^ INV;
         an  <= an_next ^ {NUM_DIGITS{INV}};
      end
   end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per digit slot (legal range >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0, meaning that 1 inverts seg, dp and an at the pins.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 SHALL have port data, input, 4*NUM_DIGITS, hex nibbles; digit i at bits [4i+3:4i]; digit 0 is least significant.
REQ-007 SHALL have port dp_in, input, NUM_DIGITS, decimal point per digit.
REQ-008 SHALL have port blank, input, NUM_DIGITS, force digit dark.
REQ-009 SHALL have port lz_en, input, 1, leading-zero suppression enable.
REQ-010 SHALL have port load, input, 1, one-cycle strobe capturing data, dp_in and blank into the staging register.
REQ-011 SHALL have port seg, output, 7, segments a (MSB) .. g (LSB), registered.
REQ-012 SHALL have port dp, output, 1, decimal point, registered.
REQ-013 SHALL have port an, output, NUM_DIGITS, one-hot digit enable, registered.
REQ-014 SHALL have port upd_ack, output, 1, one-cycle pulse when the display register takes new staged contents.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when the digit index wraps from NUM_DIGITS-1 to 0.

Function
REQ-016 SHALL decode nibbles to the following glyphs (active-high): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-017 SHALL run a prescaler counting 0..CLK_DIV-1 and assert an internal tick on the terminal count, then wrap to 0.
REQ-018 SHALL advance the digit index on tick: 0,1,..,NUM_DIGITS-1,0.
REQ-019 SHALL register seg, dp and an one cycle after tick, driving the display-register contents for the new index.
REQ-020 SHALL take data, dp_in and blank into staging and set a pending flag when load=1; a later load before the next frame boundary overwrites staging (last write wins).
REQ-021 SHALL copy staging to the display register on the cycle the index wraps to 0 while pending=1, clear pending, and pulse upd_ack in that cycle.
REQ-022 SHALL, when load coincides with the wrap cycle, bypass the load values directly into the display register, pulse upd_ack, and leave pending=0.
REQ-023 SHALL drive seg=0 and dp=0 for a digit whose blank bit is 1; its an bit still asserts.
REQ-024 SHALL, with lz_en=1, blank digit k (k>=1) when its nibble and every higher nibble are 0; digit 0 is never suppressed; dp_in still lights dp.
REQ-025 SHALL apply the ACTIVE_LOW inversion only at the output registers.
REQ-026 SHALL pulse frame_done in the same cycle as the wrap, regardless of pending.
REQ-027 SHALL, with NUM_DIGITS=1, keep an constantly active after the first tick and pulse frame_done on every tick.

Reset
REQ-028 SHALL, on rst=1, clear the prescaler, index, staging, display register and pending flag, and set upd_ack=0 and frame_done=0.
REQ-029 SHALL hold seg, dp and an at their inactive pin levels from reset until the first tick.
REQ-030 SHALL give rst priority over a coincident load or tick; a reset mid-frame discards staged data.

Structure
REQ-031 SHALL place the glyph constants and the blank glyph in a shared package, seg7_pkg.
REQ-032 SHALL place nibble-to-glyph decode in one combinational sub-module, seg7_glyph.

Verification (NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=0)
REQ-033 SHALL cover: reset, then load data=16'h12AF -> after wrap upd_ack=1; slots show an=0001 seg=1000111, an=0010 seg=1110111, an=0100 seg=1101101, an=1000 seg=0110000.
REQ-034 SHALL cover: lz_en=1, data=16'h0070 -> digits 3 and 2 seg=0, digit 1 seg=1110010, digit 0 seg=1111110.
REQ-035 SHALL cover: two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is displayed, with a single upd_ack.
REQ-036 SHALL cover: load on the wrap cycle -> the same-cycle upd_ack is asserted and the new data shows on digit 0 in that frame.
REQ-037 SHALL cover: rst asserted mid-frame with pending data -> an, seg and dp are inactive, pending is discarded, and the first tick after release shows digit 0 as 0.
REQ-038 SHALL cover: ACTIVE_LOW=1, data=16'h8888, dp_in=4'b0001 -> seg=0000000 on every slot, dp=0 on digit 0 only, and the active an bit is 0.
